// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR memory engine.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        MAC,
        WRITE,
        DONE
    } state_e;

    localparam int unsigned PIPE_LAT = 3;

    // Accumulator wide enough for TAPS full-scale products without overflow.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned coef_w,
                                              input int unsigned taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_out_quant.sv
// Output quantiser: arithmetic right shift, then saturate (FIR_SAT_EN defined) or wrap.
module fir_out_quant #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 19,
    parameter int unsigned SHIFT  = 7
) (
    input  logic [ACC_W-1:0]  i_acc,
    output logic [DATA_W-1:0] o_data
);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] w_shifted;

    assign w_shifted = $signed(i_acc) >>> SHIFT;

    always_comb begin
        o_data = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            o_data = SAT_MAX[DATA_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            o_data = SAT_MIN[DATA_W-1:0];
        end
    end
`else
    assign o_data = DATA_W'($signed(i_acc) >>> SHIFT);
`endif

endmodule

// File: rtl/fir_mem_engine.sv
// TAPS-tap signed FIR over a RAM block; per-run choice of sequential or pipelined datapath.
// Define FIR_SAT_EN to saturate quantised outputs instead of wrapping them.
module fir_mem_engine
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned SHIFT  = 7
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_sel_pipelined,
    input  logic [ADDR_W-1:0]        i_input_addr,
    input  logic [ADDR_W-1:0]        i_output_addr,
    input  logic [ADDR_W-1:0]        i_sample_count,
    input  logic                     i_coef_we,
    input  logic [$clog2(TAPS)-1:0]  i_coef_idx,
    input  logic [COEF_W-1:0]        i_coef_data,
    output logic [ADDR_W-1:0]        o_mem_addr_a,
    input  logic [DATA_W-1:0]        i_mem_rdata_a,
    output logic [ADDR_W-1:0]        o_mem_addr_b,
    output logic                     o_mem_we_b,
    output logic [DATA_W-1:0]        o_mem_wdata_b,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [31:0]              o_cycle_count
);

    localparam int unsigned IDX_W  = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);

    state_e                    r_state, w_state_next;
    logic                      r_pipe;
    logic [ADDR_W-1:0]         r_rd_ptr, r_wr_ptr, r_n, r_rd_cnt, r_wr_cnt;
    logic [IDX_W-1:0]          r_tap;
    logic [PIPE_LAT-1:0]       r_pv;
    logic [31:0]               r_cycle_count;
    logic signed [COEF_W-1:0]  r_coef [TAPS];
    logic signed [DATA_W-1:0]  r_dly  [TAPS];
    logic signed [PROD_W-1:0]  r_prod [TAPS];
    logic signed [ACC_W-1:0]   r_acc, w_sum, w_q_in;
    logic signed [PROD_W-1:0]  w_mac;
    logic [DATA_W-1:0]         w_q_out;
    logic                      w_busy, w_accept, w_rd, w_shift, w_wr, w_last_wr;

    assign w_busy    = r_state inside {READ, WAIT, MAC, WRITE};
    assign w_accept  = i_start && (r_state == IDLE || r_state == DONE);
    // Pipelined runs stay in READ; the valid pipe r_pv tracks shift/product/write stages.
    assign w_rd      = (r_state == READ) && (!r_pipe || (r_rd_cnt != r_n));
    assign w_shift   = r_pipe ? r_pv[0] : (r_state == WAIT);
    assign w_wr      = r_pipe ? r_pv[PIPE_LAT-1] : (r_state == WRITE);
    assign w_last_wr = w_wr && ((r_wr_cnt + 1'b1) == r_n);
    assign w_mac     = r_coef[r_tap] * r_dly[r_tap];

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_sum = w_sum + {{(ACC_W - PROD_W){r_prod[k][PROD_W-1]}}, r_prod[k]};
        end
    end

    assign w_q_in = r_pipe ? w_sum : r_acc;

    fir_out_quant #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_quant (
        .i_acc  (w_q_in),
        .o_data (w_q_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE, DONE: if (w_accept) w_state_next = (i_sample_count == '0) ? DONE : READ;
            READ: begin
                if (!r_pipe) begin
                    w_state_next = WAIT;
                end else if (w_last_wr) begin
                    w_state_next = DONE;
                end
            end
            WAIT:    w_state_next = MAC;
            MAC:     if (r_tap == IDX_W'(TAPS - 1)) w_state_next = WRITE;
            WRITE:   w_state_next = w_last_wr ? DONE : READ;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pipe        <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_n           <= '0;
            r_rd_cnt      <= '0;
            r_wr_cnt      <= '0;
            r_tap         <= '0;
            r_pv          <= '0;
            r_cycle_count <= '0;
            r_acc         <= '0;
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
                r_dly[k]  <= '0;
                r_prod[k] <= '0;
            end
        end else begin
            if (w_busy) r_cycle_count <= r_cycle_count + 32'd1;
            if (i_coef_we && !w_busy) r_coef[i_coef_idx] <= i_coef_data;
            if (w_accept) begin
                r_pipe        <= i_sel_pipelined;
                r_rd_ptr      <= i_input_addr;
                r_wr_ptr      <= i_output_addr;
                r_n           <= i_sample_count;
                r_rd_cnt      <= '0;
                r_wr_cnt      <= '0;
                r_tap         <= '0;
                r_pv          <= '0;
                r_cycle_count <= '0;
                r_acc         <= '0;
                for (int k = 0; k < TAPS; k++) begin
                    r_dly[k] <= '0;
                end
            end else begin
                r_pv <= {r_pv[PIPE_LAT-2:0], w_rd && r_pipe};
                if (w_rd) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
                if (w_shift) begin
                    for (int k = TAPS - 1; k > 0; k--) begin
                        r_dly[k] <= r_dly[k-1];
                    end
                    r_dly[0] <= i_mem_rdata_a;
                end
                if (r_pv[1]) begin
                    for (int k = 0; k < TAPS; k++) begin
                        r_prod[k] <= r_coef[k] * r_dly[k];
                    end
                end
                if (r_state == WAIT) begin
                    r_acc <= '0;
                    r_tap <= '0;
                end else if (r_state == MAC) begin
                    r_acc <= r_acc + {{(ACC_W - PROD_W){w_mac[PROD_W-1]}}, w_mac};
                    r_tap <= r_tap + 1'b1;
                end
            end
        end
    end

    assign o_mem_addr_a  = r_rd_ptr;
    assign o_mem_addr_b  = r_wr_ptr;
    assign o_mem_we_b    = w_wr;
    assign o_mem_wdata_b = w_q_out;
    assign o_busy        = w_busy;
    assign o_done        = (r_state == DONE);
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_fir_mem_engine.sv
// Directed self-checking bench for fir_mem_engine with a behavioural dual-port RAM.
module tb_fir_mem_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sel, coef_we;
    logic [9:0]  ia, oa, cnt;
    logic [2:0]  cidx;
    logic [7:0]  cdat;
    logic [9:0]  addr_a, addr_b;
    logic [7:0]  rdata_a, wdata_b;
    logic        we_b, busy, done;
    logic [31:0] cycle_count;

    logic        tb_we, tb_clr;
    logic [9:0]  tb_addr;
    logic [7:0]  tb_data;
    logic [7:0]  mem [1024];
    int          wr_seen = 0;

    int n_vec = 0;
    int n_err = 0;

    logic signed [7:0] cs [8];
    logic signed [7:0] xs [100];

    fir_mem_engine #(
        .DATA_W (8),
        .COEF_W (8),
        .TAPS   (8),
        .ADDR_W (10),
        .SHIFT  (7)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .i_sel_pipelined (sel),
        .i_input_addr    (ia),
        .i_output_addr   (oa),
        .i_sample_count  (cnt),
        .i_coef_we       (coef_we),
        .i_coef_idx      (cidx),
        .i_coef_data     (cdat),
        .o_mem_addr_a    (addr_a),
        .i_mem_rdata_a   (rdata_a),
        .o_mem_addr_b    (addr_b),
        .o_mem_we_b      (we_b),
        .o_mem_wdata_b   (wdata_b),
        .o_busy          (busy),
        .o_done          (done),
        .o_cycle_count   (cycle_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata_a <= mem[addr_a];
        if (tb_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end
        if (tb_we) mem[tb_addr] <= tb_data;
        if (we_b) begin
            mem[addr_b] <= wdata_b;
            wr_seen <= wr_seen + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic set_coef(input logic [2:0] idx, input logic [7:0] val);
        coef_we = 1'b1; cidx = idx; cdat = val;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic start_run(input logic mode, input logic [9:0] ia_v, input logic [9:0] oa_v,
                             input logic [9:0] n_v);
        sel = mode; ia = ia_v; oa = oa_v; cnt = n_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
        check("done_reached", {31'b0, done}, 32'd1);
    endtask

    task automatic run(input logic mode, input logic [9:0] ia_v, input logic [9:0] oa_v,
                       input logic [9:0] n_v, output logic [31:0] cc_v);
        start_run(mode, ia_v, oa_v, n_v);
        wait_done();
        cc_v = cycle_count;
    endtask

    task automatic check_out(input string tag, input logic [9:0] a, input logic [7:0] exp);
        check(tag, {24'b0, mem[a]}, {24'b0, exp});
    endtask

    function automatic logic [7:0] model_y(input int n);
        int acc = 0;
        for (int k = 0; k < 8; k++) begin
            if (n - k >= 0) acc += int'(cs[k]) * int'(xs[n-k]);
        end
        acc = acc >>> 7;
`ifdef FIR_SAT_EN
        if (acc > 127) acc = 127;
        else if (acc < -128) acc = -128;
`endif
        return acc[7:0];
    endfunction

    initial begin
        logic [31:0] cc;
        int          wr0;
        int          diffs;

        rst = 1'b1; start = 1'b0; sel = 1'b0; coef_we = 1'b0;
        ia = '0; oa = '0; cnt = '0; cidx = '0; cdat = '0;
        tb_we = 1'b0; tb_addr = '0; tb_data = '0; tb_clr = 1'b1;
        cs = '{8'sd3, -8'sd5, 8'sd17, -8'sd33, 8'sd64, -8'sd100, 8'sd127, -8'sd128};
        for (int i = 0; i < 100; i++) xs[i] = 8'(i * 37 + 11);
        repeat (3) @(negedge clk);

        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_mem_if", {3'b0, we_b, addr_a, addr_b, wdata_b}, 32'd0);
        tb_clr = 1'b0; rst = 1'b0;
        @(negedge clk);

        // Step response, both modes.
        for (int k = 0; k < 8; k++) set_coef(3'(k), 8'd16);
        for (int i = 0; i < 10; i++) poke(10'(i), 8'd40);
        run(1'b0, 10'd0, 10'd512, 10'd10, cc);
        check("step_seq_cc", cc, 32'd110);
        for (int i = 0; i < 10; i++) check_out("step_seq_y", 10'(512 + i), (i < 8) ? 8'(5 * (i + 1)) : 8'd40);
        run(1'b1, 10'd0, 10'd540, 10'd10, cc);
        check("step_pipe_cc", cc, 32'd13);
        for (int i = 0; i < 10; i++) check_out("step_pipe_y", 10'(540 + i), (i < 8) ? 8'(5 * (i + 1)) : 8'd40);

        // N=100 with mixed-sign coefficients: cycle counts and mode equivalence.
        for (int k = 0; k < 8; k++) set_coef(3'(k), cs[k]);
        for (int i = 0; i < 100; i++) poke(10'(i), xs[i]);
        run(1'b0, 10'd0, 10'd200, 10'd100, cc);
        check("n100_seq_cc", cc, 32'd1100);
        run(1'b1, 10'd0, 10'd400, 10'd100, cc);
        check("n100_pipe_cc", cc, 32'd103);
        diffs = 0;
        for (int i = 0; i < 100; i++) if (mem[200+i] !== mem[400+i]) diffs++;
        check("n100_mode_diffs", 32'(diffs), 32'd0);
        check_out("n100_model_y0", 10'd200, model_y(0));
        check_out("n100_model_y50", 10'd250, model_y(50));
        check_out("n100_model_y99", 10'd499, model_y(99));

        // Impulse through a ramp of coefficients.
        for (int k = 0; k < 8; k++) set_coef(3'(k), 8'(8 * k + 8));
        poke(10'd0, 8'd127);
        for (int i = 1; i < 8; i++) poke(10'(i), 8'd0);
        run(1'b0, 10'd0, 10'd300, 10'd8, cc);
        for (int i = 0; i < 8; i++) check_out("imp_seq_y", 10'(300 + i), 8'(8 * i + 7));
        run(1'b1, 10'd0, 10'd320, 10'd8, cc);
        for (int i = 0; i < 8; i++) check_out("imp_pipe_y", 10'(320 + i), 8'(8 * i + 7));

        // Full-scale positive and negative windows.
        for (int k = 0; k < 8; k++) set_coef(3'(k), 8'd127);
        for (int i = 0; i < 8; i++) poke(10'(i), 8'd127);
        run(1'b0, 10'd0, 10'd800, 10'd8, cc);
        run(1'b1, 10'd0, 10'd810, 10'd8, cc);
`ifdef FIR_SAT_EN
        check_out("sat_pos_seq", 10'd807, 8'h7F);
        check_out("sat_pos_pipe", 10'd817, 8'h7F);
`else
        check_out("wrap_pos_seq", 10'd807, 8'hF0);
        check_out("wrap_pos_pipe", 10'd817, 8'hF0);
`endif
        for (int i = 0; i < 8; i++) poke(10'(i), 8'h80);
        run(1'b0, 10'd0, 10'd820, 10'd8, cc);
        run(1'b1, 10'd0, 10'd830, 10'd8, cc);
`ifdef FIR_SAT_EN
        check_out("sat_neg_seq", 10'd827, 8'h80);
        check_out("sat_neg_pipe", 10'd837, 8'h80);
`else
        check_out("wrap_neg_seq", 10'd827, 8'h08);
        check_out("wrap_neg_pipe", 10'd837, 8'h08);
`endif

        // Input address wrap: 1020..1023 then 0..3, single-tap half gain.
        set_coef(3'd0, 8'd64);
        for (int k = 1; k < 8; k++) set_coef(3'(k), 8'd0);
        for (int i = 0; i < 8; i++) poke(10'(1020 + i), 8'(2 * (i + 1)));
        run(1'b0, 10'd1020, 10'd500, 10'd8, cc);
        for (int i = 0; i < 8; i++) check_out("wrap_seq_y", 10'(500 + i), 8'(i + 1));
        run(1'b1, 10'd1020, 10'd510, 10'd8, cc);
        for (int i = 0; i < 8; i++) check_out("wrap_pipe_y", 10'(510 + i), 8'(i + 1));

        // start and coef_we mid-run must not disturb the run.
        for (int k = 0; k < 8; k++) set_coef(3'(k), 8'd16);
        for (int i = 0; i < 10; i++) poke(10'(i), 8'd40);
        start_run(1'b0, 10'd0, 10'd600, 10'd10);
        repeat (20) @(negedge clk);
        start = 1'b1; sel = 1'b1; ia = 10'd5; oa = 10'd0; cnt = 10'd1;
        coef_we = 1'b1; cidx = 3'd0; cdat = 8'd0;
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0;
        check("midrun_busy", {31'b0, busy}, 32'd1);
        wait_done();
        check("midrun_cc", cycle_count, 32'd110);
        for (int i = 0; i < 10; i++) check_out("midrun_y", 10'(600 + i), (i < 8) ? 8'(5 * (i + 1)) : 8'd40);
        check_out("midrun_input_intact", 10'd0, 8'd40);

        // Reset mid-run aborts with no further writes.
        start_run(1'b1, 10'd0, 10'd900, 10'd100);
        repeat (30) @(negedge clk);
        check("rstrun_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        wr0 = wr_seen;
        check("rstrun_outputs", {busy, done, we_b, addr_a, addr_b, wdata_b}, 32'd0);
        check("rstrun_cc", cycle_count, 32'd0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstrun_no_writes", 32'(wr_seen - wr0), 32'd0);
        check("rstrun_idle", {30'b0, busy, done}, 32'd0);

        // N=0 straight to DONE with no memory access.
        start_run(1'b0, 10'd0, 10'd700, 10'd0);
        check("n0_done", {31'b0, done}, 32'd1);
        check("n0_busy", {31'b0, busy}, 32'd0);
        check("n0_cc", cycle_count, 32'd0);
        repeat (3) @(negedge clk);
        check("n0_no_writes", 32'(wr_seen - wr0), 32'd0);

        // Coefficient bank was cleared by the reset.
        for (int i = 0; i < 8; i++) poke(10'(i), 8'd40);
        run(1'b1, 10'd0, 10'd960, 10'd8, cc);
        check("coef_cleared_cc", cc, 32'd11);
        check_out("coef_cleared_y0", 10'd960, 8'd0);
        check_out("coef_cleared_y7", 10'd967, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fir_mem_engine.md
Name: fir_mem_engine

Overview:
- Parametrised successor to the fixed 8-bit FIR core.
- Runs a TAPS-tap signed FIR over a block of samples held in a shared dual-port RAM. Port A reads input samples; port B writes filtered outputs.
- Runtime mode: sequential (one MAC per cycle) or pipelined (one sample per cycle). Both modes share one delay line and coefficient bank.
- Reports a cycle count for each run so the two modes can be compared.

Parameters:
- DATA_W, 8: sample and output width, signed.
- COEF_W, 8: coefficient width, signed.
- TAPS, 8: number of taps, 2..32.
- ADDR_W, 10: RAM address width.
- SHIFT, 7: arithmetic right shift applied to the accumulator before quantisation.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle run request; ignored unless idle or done.
- sel_pipelined  in  1  mode select, sampled at start (0 = sequential, 1 = pipelined).
- input_addr  in  ADDR_W  first input address, sampled at start.
- output_addr  in  ADDR_W  first output address, sampled at start.
- sample_count  in  ADDR_W  number of samples N, sampled at start.
- coef_we  in  1  coefficient write strobe; ignored while busy.
- coef_idx  in  clog2(TAPS)  coefficient index.
- coef_data  in  COEF_W  coefficient value.
- mem_addr_a  out  ADDR_W  read address.
- mem_rdata_a  in  DATA_W  read data, valid 1 cycle after address.
- mem_addr_b  out  ADDR_W  write address.
- mem_we_b  out  1  write enable.
- mem_wdata_b  out  DATA_W  write data.
- busy  out  1  run in progress.
- done  out  1  level; set at run end, cleared by the next accepted start.
- cycle_count  out  32  cycles spent in the current or last run.

Behaviour:
- Reset: every output is 0; the coefficient bank and delay line are 0; state is IDLE. Reset mid-run aborts the run immediately, and no further writes are issued.
- Start accept: at an accepted start, clear the delay line, zero cycle_count, drop done, and latch the configuration inputs. The computed output is y[n] = sum over k of c[k]*x[n-k], with x[negative] = 0.
- Accumulator: signed, ACC_W = DATA_W + COEF_W + clog2(TAPS). Output = quantise(acc >>> SHIFT), with arithmetic (floor) shift.
- Addressing: addresses increment modulo 2^ADDR_W, so wrap-around is legal.
- cycle_count: increments every cycle that busy = 1 and freezes when done rises.
- Sequential FSM: IDLE -> READ (issue addr) -> WAIT (shift sample into delay line) -> MAC (TAPS cycles, one tap per cycle) -> WRITE (mem_we_b for 1 cycle) -> READ, or DONE after the N-th sample.
  - Total cycle_count = N*(TAPS+3).
- Pipelined mode:
  - Read of sample i is issued at run cycle i.
  - Cycle i+1: data shifts into the delay line.
  - Cycle i+2: all TAPS products are registered.
  - Cycle i+3: the summed result is registered and written.
  - Total cycle_count = N+3.
- Both modes produce bit-identical outputs.
- N = 0: go straight to DONE the cycle after start, with no memory access and cycle_count = 0.
- start while busy: ignored. coef_we while busy: ignored.
- Overlapping input and output regions: results are undefined. Software is responsible for avoiding overlap.

Optional Feature:
- FIR_SAT_EN defined: the quantiser saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- FIR_SAT_EN undefined: the quantiser keeps the low DATA_W bits (wrap).

Decomposition:
- Package fir_pkg holds:
  - state enum {IDLE, READ, WAIT, MAC, WRITE, DONE};
  - pipeline latency constant PIPE_LAT = 3;
  - ACC_W calculation function.
- One sub-module, fir_out_quant: combinational shift plus saturate/wrap, used by both modes.

Test Plan:
Common setup: TAPS=8, SHIFT=7, DATA_W=8.
- Step: all coefficients 16, x[i] = 40, N=10, input_addr 0, output_addr 512 -> outputs 5,10,15,...,40,40,40 in both modes.
- Cycle counts: N=100 -> sequential cycle_count 1100, pipelined 103; outputs compared word-for-word and must match.
- Impulse: c[k] = 8k+8, x[0]=127, rest 0, N=8 -> y[k] = floor(127*(8k+8)/128), i.e. 7,15,23,31,39,47,55,63.
- Saturation:
  - All coefficients 127 and x = 127 -> output 127 with FIR_SAT_EN defined, wrapped value 0xF0 (1008 mod 256) without.
  - x = -128 -> -128 with FIR_SAT_EN defined.
- Wrap and boundaries:
  - input_addr 1020, N=8 -> reads 1020..1023 then 0..3.
  - N=0 -> done the next cycle with cycle_count 0.
- Robustness:
  - start and coef_we asserted mid-run -> no effect.
  - rst asserted mid-run -> no writes afterwards, and all outputs read 0.
